// File: rtl/cmp_seq_ctrl_if.sv
// rtl/cmp_seq_ctrl_if.sv - request/result handshake bundle for the multi-word compare sequencer
interface cmp_seq_ctrl_if #(
    parameter int N     = 32,
    parameter int WORDS = 2
);
    localparam int W  = N * WORDS;
    localparam int UW = $clog2(WORDS + 1);

    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_cmp;
    logic          res_valid;
    logic          res_ready;
    logic          eq;
    logic          neq;
    logic          lt;
    logic          lte;
    logic          gt;
    logic          gte;
    logic [UW-1:0] words_used;
    logic          busy;

    modport master (
        output start_valid, a, b, signed_cmp, res_ready,
        input  start_ready, res_valid, eq, neq, lt, lte, gt, gte, words_used, busy
    );

    modport slave (
        input  start_valid, a, b, signed_cmp, res_ready,
        output start_ready, res_valid, eq, neq, lt, lte, gt, gte, words_used, busy
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - MSW-first multi-word compare sequencer sharing one N-bit comparator
module cmp_word #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);
    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

module cmp_seq_ctrl #(
    parameter int N     = 32,
    parameter int WORDS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_seq_ctrl_if.slave     bus
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int UW = $clog2(WORDS + 1);
    localparam logic [IW-1:0] IDX_MSW = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q, b_q;
    logic          sgn_q;
    logic [N-1:0]  word_a, word_b;
    logic          c_eq, c_lt, c_gt;
    logic          accept, finish;
    logic          eq_q, neq_q, lt_q, gt_q;
    logic [UW-1:0] used_q;
    logic          start_ready_c, res_valid_c, busy_c;

    // Flipping the sign bit of the top word turns a two's-complement
    // compare into an unsigned one; lower words are magnitude only.
    always_comb begin
        word_a = a_q[int'(idx) * N +: N];
        word_b = b_q[int'(idx) * N +: N];
        if (sgn_q && (idx == IDX_MSW)) begin
            word_a[N-1] = ~word_a[N-1];
            word_b[N-1] = ~word_b[N-1];
        end
    end

    cmp_word #(.N(N)) u_cmp (
        .a  (word_a),
        .b  (word_b),
        .eq (c_eq),
        .lt (c_lt),
        .gt (c_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        start_ready_c = 1'b0;
        res_valid_c   = 1'b0;
        busy_c        = 1'b0;
        accept        = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                start_ready_c = 1'b1;
                if (bus.start_valid) begin
                    accept    = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                busy_c = 1'b1;
                if (!c_eq || (idx == '0)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c      = 1'b1;
                res_valid_c = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On an all-equal finish the comparator already reports eq=1, lt=gt=0,
    // so both termination cases load the same way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            eq_q   <= 1'b0;
            neq_q  <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            used_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sgn_q <= bus.signed_cmp;
                idx   <= IDX_MSW;
            end else if ((state == CMP) && !finish) begin
                idx <= idx - 1'b1;
            end
            if (finish) begin
                eq_q   <= c_eq;
                neq_q  <= ~c_eq;
                lt_q   <= c_lt;
                gt_q   <= c_gt;
                used_q <= UW'(WORDS - int'(idx));
            end
        end
    end

    assign bus.start_ready = start_ready_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.busy        = busy_c;
    assign bus.eq          = eq_q;
    assign bus.neq         = neq_q;
    assign bus.lt          = lt_q;
    assign bus.gt          = gt_q;
    assign bus.lte         = lt_q | eq_q;
    assign bus.gte         = gt_q | eq_q;
    assign bus.words_used  = used_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - directed bench for cmp_seq_ctrl (N=8, WORDS=4 and N=8, WORDS=1)
module tb_cmp_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl_if #(.N(8), .WORDS(4)) bus4 ();
    cmp_seq_ctrl_if #(.N(8), .WORDS(1)) bus1 ();

    cmp_seq_ctrl #(.N(8), .WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    cmp_seq_ctrl #(.N(8), .WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // {eq, neq, lt, lte, gt, gte}
    wire [5:0] flags4 = {bus4.eq, bus4.neq, bus4.lt, bus4.lte, bus4.gt, bus4.gte};
    wire [5:0] flags1 = {bus1.eq, bus1.neq, bus1.lt, bus1.lte, bus1.gt, bus1.gte};
    localparam logic [5:0] F_EQ = 6'b100101;
    localparam logic [5:0] F_LT = 6'b011100;
    localparam logic [5:0] F_GT = 6'b010011;

    // Issues one request on bus4 and returns edges from accept to res_valid (-1 on timeout).
    task automatic req4(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        int n;
        n = 0;
        while (!bus4.start_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus4.a = a; bus4.b = b; bus4.signed_cmp = s; bus4.start_valid = 1'b1;
        @(posedge clk); #1;
        bus4.start_valid = 1'b0;
        bus4.a = ~a; bus4.b = a;
        lat = 0;
        while (!bus4.res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus4.res_valid) lat = -1;
    endtask

    task automatic test_reset();
        tests++;
        if ({flags4, bus4.words_used, bus4.res_valid, bus4.busy} !== 11'd0) begin
            fails++; $display("FAIL reset_outputs got %b want 0", {flags4, bus4.words_used, bus4.res_valid, bus4.busy});
        end
        tests++;
        if (bus4.start_ready !== 1'b1) begin
            fails++; $display("FAIL reset_start_ready got %b want 1", bus4.start_ready);
        end
    endtask

    task automatic test_vectors4();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vs [5];
        logic [5:0]  vf [5];
        logic [2:0]  vw [5];
        int          lat;
        va = '{32'h12345678, 32'h80000000, 32'h80000000, 32'h11223344, 32'hFFFFFFFE};
        vb = '{32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h11224344, 32'hFFFFFFFF};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vf = '{F_EQ, F_GT, F_LT, F_LT, F_LT};
        vw = '{3'd4, 3'd1, 3'd1, 3'd3, 3'd4};
        bus4.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req4(va[i], vb[i], vs[i], lat);
            tests++;
            if (flags4 !== vf[i]) begin
                fails++; $display("FAIL vec%0d_flags got %b want %b", i, flags4, vf[i]);
            end
            tests++;
            if (bus4.words_used !== vw[i]) begin
                fails++; $display("FAIL vec%0d_words_used got %0d want %0d", i, bus4.words_used, vw[i]);
            end
            tests++;
            if (lat !== int'(vw[i])) begin
                fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vw[i]);
            end
            @(posedge clk); #1;
            tests++;
            if (bus4.res_valid !== 1'b0 || bus4.start_ready !== 1'b1) begin
                fails++; $display("FAIL vec%0d_release got res_valid=%b start_ready=%b want 0/1", i, bus4.res_valid, bus4.start_ready);
            end
        end
    endtask

    task automatic test_words1();
        int lat;
        bus1.res_ready = 1'b1;
        bus1.a = 8'h80; bus1.b = 8'h01; bus1.signed_cmp = 1'b1; bus1.start_valid = 1'b1;
        @(posedge clk); #1;
        bus1.start_valid = 1'b0;
        lat = 0;
        while (!bus1.res_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (lat !== 1) begin
            fails++; $display("FAIL w1_latency got %0d want 1", lat);
        end
        tests++;
        if (flags1 !== F_LT || bus1.words_used !== 1'b1) begin
            fails++; $display("FAIL w1_result got %b/%0d want %b/1", flags1, bus1.words_used, F_LT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int  lat;
        bit  stable_ok;
        bus4.res_ready = 1'b0;
        req4(32'h00000001, 32'h00000002, 1'b0, lat);
        tests++;
        if (flags4 !== F_LT || bus4.words_used !== 3'd4 || lat !== 4) begin
            fails++; $display("FAIL bp_result got %b/%0d lat %0d want %b/4 lat 4", flags4, bus4.words_used, lat, F_LT);
        end
        stable_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus4.a = 32'h55; bus4.b = 32'h55; bus4.signed_cmp = 1'b1; bus4.start_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus4.start_valid = 1'b0;
            if (bus4.res_valid !== 1'b1 || bus4.start_ready !== 1'b0 || bus4.busy !== 1'b1 ||
                flags4 !== F_LT || bus4.words_used !== 3'd4) stable_ok = 1'b0;
        end
        tests++;
        if (stable_ok !== 1'b1) begin
            fails++; $display("FAIL bp_hold got unstable/accepted want held DONE");
        end
        bus4.res_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus4.res_valid !== 1'b0 || bus4.start_ready !== 1'b1 || bus4.busy !== 1'b0) begin
            fails++; $display("FAIL bp_release got rv=%b sr=%b busy=%b want 0/1/0", bus4.res_valid, bus4.start_ready, bus4.busy);
        end
        req4(32'hA0000000, 32'h20000000, 1'b1, lat);
        tests++;
        if (flags4 !== F_LT || bus4.words_used !== 3'd1 || lat !== 1) begin
            fails++; $display("FAIL bp_next got %b/%0d lat %0d want %b/1 lat 1", flags4, bus4.words_used, lat, F_LT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        bit pulsed;
        bus4.res_ready = 1'b1;
        bus4.a = 32'h0; bus4.b = 32'h0; bus4.signed_cmp = 1'b0; bus4.start_valid = 1'b1;
        @(posedge clk); #1;
        bus4.start_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({flags4, bus4.words_used, bus4.res_valid, bus4.busy} !== 11'd0) begin
            fails++; $display("FAIL midop_reset got %b want 0", {flags4, bus4.words_used, bus4.res_valid, bus4.busy});
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus4.start_ready !== 1'b1) begin
            fails++; $display("FAIL midop_start_ready got %b want 1", bus4.start_ready);
        end
        pulsed = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus4.res_valid) pulsed = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (pulsed !== 1'b0) begin
            fails++; $display("FAIL midop_no_result got res_valid pulse want none");
        end
    endtask

    initial begin
        bus4.start_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.signed_cmp = 1'b0; bus4.res_ready = 1'b1;
        bus1.start_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.signed_cmp = 1'b0; bus1.res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_vectors4();
        test_words1();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
